mouse_quad_gen: RTL

Parametrised generator for Atari ST mouse quadrature signals. It replaces the fixed joystick-mouse and trackball glue logic in the toplevel. Four raw direction inputs and two buttons are turned into the 6-bit joy0 vector that goes to the atarist core. Two runtime-selectable modes are supported: joystick emulation with acceleration, and edge-counting trackball. Each axis has a saturating pending-step accumulator and a rate-limited Gray-code step engine, so fast trackball bursts are not lost.

---
 rtl/mouse_quad_gen.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/mouse_quad_gen.sv
// Atari ST mouse quadrature generator: joystick-emulation or trackball inputs are
// accumulated per axis and replayed as rate-limited Gray-code steps on joy_out.
module mouse_quad_gen #(
  parameter int STEP_DIV    = 32000,
  parameter int CNT_W       = 6,
  parameter int DEB_CYCLES  = 320,
  parameter int ACCEL_TICKS = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mode,
  input  logic             up_n,
  input  logic             down_n,
  input  logic             left_n,
  input  logic             right_n,
  input  logic             btn_l_n,
  input  logic             btn_r_n,
  input  logic             ovf_clr,
  output logic [5:0]       joy_out,
  output logic [CNT_W-1:0] dx_pend,
  output logic [CNT_W-1:0] dy_pend,
  output logic             ovf
);

  localparam int PW = $clog2(STEP_DIV);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int AW = $clog2(ACCEL_TICKS + 1);
  localparam int SW = CNT_W + 2;
  localparam logic [PW-1:0]        PRESC_LAST = PW'(STEP_DIV - 1);
  localparam logic [PW-1:0]        PRESC_HALF = PW'(STEP_DIV / 2 - 1);
  localparam logic signed [SW-1:0] PEND_MAX   = SW'((2 ** (CNT_W - 1)) - 1);
  localparam logic signed [SW-1:0] PEND_MIN   = SW'(-(2 ** (CNT_W - 1)));

  // Bit order of the synchronised vector: up, down, left, right, btn_l, btn_r.
  logic [5:0] rawN;
  logic [5:0] syncA_q, syncB_q;
  logic [5:0] lvl;

  assign rawN = {btn_r_n, btn_l_n, right_n, left_n, down_n, up_n};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      syncA_q <= '1;
      syncB_q <= '1;
    end else begin
      syncA_q <= rawN;
      syncB_q <= syncA_q;
    end
  end

  assign lvl = ~syncB_q;

  // The first cycle after reset release only primes prevLvl_q.
  logic [3:0] prevLvl_q;
  logic       armed_q;
  logic [3:0] edges;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prevLvl_q <= '0;
      armed_q   <= 1'b0;
    end else begin
      prevLvl_q <= lvl[3:0];
      armed_q   <= 1'b1;
    end
  end

  assign edges = armed_q ? (lvl[3:0] ^ prevLvl_q) : 4'b0000;

  logic mode_q, modePrev_q, modeChg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q     <= 1'b0;
      modePrev_q <= 1'b0;
    end else begin
      mode_q     <= mode;
      modePrev_q <= mode_q;
    end
  end

  assign modeChg = mode_q ^ modePrev_q;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick, htick;

  assign tick  = (presc_q == PRESC_LAST);
  assign htick = (presc_q == PRESC_HALF);

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (modeChg || tick) presc_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) presc_q <= '0;
    else          presc_q <= presc_d;
  end

  // Index 0 is btn_l, index 1 is btn_r; any bounce restarts the stability count.
  for (genvar b = 0; b < 2; b++) begin : debounce
    logic          deb_q, deb_d;
    logic [DW-1:0] cnt_q, cnt_d;

    always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (lvl[4+b] != deb_q) begin
        if (cnt_q == DW'(DEB_CYCLES - 1)) deb_d = lvl[4+b];
        else                              cnt_d = cnt_q + DW'(1);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        deb_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        deb_q <= deb_d;
        cnt_q <= cnt_d;
      end
    end
  end

  // Axis 0 is X (right +, left -), axis 1 is Y (down +, up -).
  for (genvar a = 0; a < 2; a++) begin : axis
    localparam int PLUS  = (a == 0) ? 3 : 1;
    localparam int MINUS = (a == 0) ? 2 : 0;

    logic [CNT_W-1:0]     pend_q, pend_d;
    logic [AW-1:0]        accel_q, accel_d;
    logic [1:0]           quad_q, quad_d;
    logic                 fast, held, stepEvt, clamp;
    logic signed [SW-1:0] inStep, consume, pendExt, sum;

    assign fast    = mode_q && (accel_q == AW'(ACCEL_TICKS));
    assign held    = lvl[PLUS] ^ lvl[MINUS];
    assign stepEvt = !modeChg && (tick || (fast && htick));
    assign pendExt = SW'($signed(pend_q));

    always_comb begin
      inStep = '0;
      if (!mode_q) begin
        if (edges[PLUS])  inStep = inStep + SW'(1);
        if (edges[MINUS]) inStep = inStep - SW'(1);
      end else if (tick && held) begin
        inStep = fast ? SW'(2) : SW'(1);
        if (lvl[MINUS]) inStep = -inStep;
      end
    end

    // Gray sequence forward is 00,01,11,10; backward walks it in reverse.
    always_comb begin
      consume = '0;
      quad_d  = quad_q;
      if (stepEvt && (pendExt > 0)) begin
        consume = SW'(1);
        quad_d  = {quad_q[0], ~quad_q[1]};
      end else if (stepEvt && (pendExt < 0)) begin
        consume = -SW'(1);
        quad_d  = {~quad_q[0], quad_q[1]};
      end
    end

    always_comb begin
      sum    = pendExt + inStep - consume;
      clamp  = 1'b0;
      pend_d = sum[CNT_W-1:0];
      if (sum > PEND_MAX) begin
        pend_d = PEND_MAX[CNT_W-1:0];
        clamp  = 1'b1;
      end else if (sum < PEND_MIN) begin
        pend_d = PEND_MIN[CNT_W-1:0];
        clamp  = 1'b1;
      end
      if (modeChg) pend_d = '0;
    end

    always_comb begin
      accel_d = accel_q;
      if (modeChg) begin
        accel_d = '0;
      end else if (mode_q && tick) begin
        if (!held)                             accel_d = '0;
        else if (accel_q != AW'(ACCEL_TICKS))  accel_d = accel_q + AW'(1);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pend_q  <= '0;
        accel_q <= '0;
        quad_q  <= 2'b00;
      end else begin
        pend_q  <= pend_d;
        accel_q <= accel_d;
        quad_q  <= quad_d;
      end
    end
  end

  logic ovfSet, ovf_q;

  assign ovfSet = (axis[0].clamp || axis[1].clamp) && !modeChg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     ovf_q <= 1'b0;
    else if (ovfSet)  ovf_q <= 1'b1;
    else if (ovf_clr) ovf_q <= 1'b0;
  end

  // Quadrature bits show the new step the cycle after it is taken; buttons get one extra stage.
  logic [5:0] joy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) joy_q <= '0;
    else          joy_q <= {debounce[1].deb_q, debounce[0].deb_q, axis[0].quad_d, axis[1].quad_d};
  end

  assign joy_out = joy_q;
  assign dx_pend = axis[0].pend_q;
  assign dy_pend = axis[1].pend_q;
  assign ovf     = ovf_q;

endmodule
